// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, op codes, FSM encoding.
// Latency: n/a (constants and pure combinational helper functions only).
// Backpressure: n/a.
// Contents: RegBus/RegAddrBus/AluOpBus widths, EXE_*_OP codes, ZeroWord, NOPRegAddr,
// WriteDisable, mem_state_e, and op-classification helpers used by mem_stage/mem_lane_fmt.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic                  WriteDisable = 1'b0;

    // Load/store op codes; anything else is treated as a non-memory op.
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic op_is_load(input logic [AluOpBus-1:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic op_is_store(input logic [AluOpBus-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic op_is_mem(input logic [AluOpBus-1:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    function automatic logic op_is_half(input logic [AluOpBus-1:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    endfunction

    function automatic logic op_is_word(input logic [AluOpBus-1:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

    // True when the low address bits do not match the access size.
    function automatic logic op_misaligned(input logic [AluOpBus-1:0] op,
                                           input logic [1:0]          off);
        return (op_is_half(op) && off[0]) || (op_is_word(op) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: store sel/wdata from op/offset/reg2, load extraction/extension.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow inputs.
// Ports: st_op_i/st_off_i/st_reg2_i (store/issue side), ld_op_i/ld_off_i/ld_rdata_i
// (load side, from the latched access), eff_off_o (size-aligned offset), sel_o, wdata_o, ldata_o.
module mem_lane_fmt
    import mem_stage_pkg::*;
(
    input  logic [AluOpBus-1:0] st_op_i,
    input  logic [1:0]          st_off_i,
    input  logic [RegBus-1:0]   st_reg2_i,
    input  logic [AluOpBus-1:0] ld_op_i,
    input  logic [1:0]          ld_off_i,
    input  logic [RegBus-1:0]   ld_rdata_i,
    output logic [1:0]          eff_off_o,
    output logic [3:0]          sel_o,
    output logic [RegBus-1:0]   wdata_o,
    output logic [RegBus-1:0]   ldata_o
);

    // Halfword/word ops ignore the low address bits they cannot use.
    always_comb begin
        eff_off_o = st_off_i;
        if (op_is_word(st_op_i)) begin
            eff_off_o = 2'b00;
        end else if (op_is_half(st_op_i)) begin
            eff_off_o = {st_off_i[1], 1'b0};
        end
    end

    // Big-endian lanes: offset 0 is sel[3] / data[31:24].
    always_comb begin
        sel_o   = 4'b1111;
        wdata_o = st_reg2_i;
        if (op_is_half(st_op_i)) begin
            sel_o   = eff_off_o[1] ? 4'b0011 : 4'b1100;
            wdata_o = {2{st_reg2_i[15:0]}};
        end else if (!op_is_word(st_op_i)) begin
            sel_o   = 4'b1000 >> eff_off_o;
            wdata_o = {4{st_reg2_i[7:0]}};
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'h00;
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[31:24];
            2'd1:    ld_byte = ld_rdata_i[23:16];
            2'd2:    ld_byte = ld_rdata_i[15:8];
            default: ld_byte = ld_rdata_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[15:0] : ld_rdata_i[31:16];
    end

    always_comb begin
        ldata_o = ZeroWord;
        case (ld_op_i)
            EXE_LB_OP:  ldata_o = {{24{ld_byte[7]}}, ld_byte};
            EXE_LBU_OP: ldata_o = {24'h000000, ld_byte};
            EXE_LH_OP:  ldata_o = {{16{ld_half[15]}}, ld_half};
            EXE_LHU_OP: ldata_o = {16'h0000, ld_half};
            EXE_LW_OP:  ldata_o = ld_rdata_i;
            default:    ldata_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage + MEM/WB register; loads/stores over a single-outstanding req/ack bus.
// Latency: non-memory 1 cycle; memory 2 cycles + 1 per bus wait state.
// Backpressure: stallreq high from issue until the ack cycle; dbus_req held until dbus_ack.
// Ports: EX/MEM inputs mem_*, data bus dbus_*, stallreq to pipeline control, MEM/WB outputs wb_*,
// excp_align. Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned halfword/word ops trap
// instead of accessing the bus); undefined means low address bits are forced aligned.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [AluOpBus-1:0]   mem_aluop,
    input  logic [RegBus-1:0]     mem_addr,
    input  logic [RegBus-1:0]     mem_reg2,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [RegBus-1:0]     dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [RegBus-1:0]     dbus_wdata,
    input  logic [RegBus-1:0]     dbus_rdata,
    input  logic                  dbus_ack,
    output logic                  stallreq,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  excp_align
);

    mem_state_e state_q, state_d;

    logic mem_op;
    logic misalign;
    logic issue;
    logic done;

    // Access context captured at issue; EX/MEM is frozen anyway, but this keeps the
    // load formatting independent of whatever upstream presents after the ack edge.
    logic [AluOpBus-1:0]   acc_op_q;
    logic [1:0]            acc_off_q;
    logic [RegAddrBus-1:0] acc_wd_q;
    logic                  acc_wreg_q;

    logic                  dbus_req_q;
    logic                  dbus_we_q;
    logic [RegBus-1:0]     dbus_addr_q;
    logic [3:0]            dbus_sel_q;
    logic [RegBus-1:0]     dbus_wdata_q;
    logic [RegAddrBus-1:0] wb_wd_q;
    logic                  wb_wreg_q;
    logic [RegBus-1:0]     wb_wdata_q;

    logic [1:0]            eff_off;
    logic [3:0]            fmt_sel;
    logic [RegBus-1:0]     fmt_wdata;
    logic [RegBus-1:0]     fmt_ldata;

    assign mem_op = op_is_mem(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op && op_misaligned(mem_aluop, mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // A trapped misaligned op never touches the bus and never stalls.
    assign issue = mem_op && !misalign;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = issue ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = dbus_ack ? ST_IDLE : ST_ACCESS;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Stall drops in the ack cycle so upstream advances at that edge.
    always_comb begin
        stallreq = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stallreq = issue;
            end
            ST_ACCESS: begin
                stallreq = !dbus_ack;
                done     = dbus_ack;
            end
            default: begin
                stallreq = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    mem_lane_fmt u_lane_fmt (
        .st_op_i    (mem_aluop),
        .st_off_i   (mem_addr[1:0]),
        .st_reg2_i  (mem_reg2),
        .ld_op_i    (acc_op_q),
        .ld_off_i   (acc_off_q),
        .ld_rdata_i (dbus_rdata),
        .eff_off_o  (eff_off),
        .sel_o      (fmt_sel),
        .wdata_o    (fmt_wdata),
        .ldata_o    (fmt_ldata)
    );

    // Bus request side and captured access context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= ZeroWord;
            dbus_sel_q   <= 4'b0000;
            dbus_wdata_q <= ZeroWord;
            acc_op_q     <= '0;
            acc_off_q    <= 2'b00;
            acc_wd_q     <= NOPRegAddr;
            acc_wreg_q   <= WriteDisable;
        end else if ((state_q == ST_IDLE) && issue) begin
            dbus_req_q   <= 1'b1;
            dbus_we_q    <= op_is_store(mem_aluop);
            dbus_addr_q  <= {mem_addr[RegBus-1:2], 2'b00};
            dbus_sel_q   <= fmt_sel;
            dbus_wdata_q <= fmt_wdata;
            acc_op_q     <= mem_aluop;
            acc_off_q    <= eff_off;
            acc_wd_q     <= mem_wd;
            acc_wreg_q   <= mem_wreg;
        end else if (done) begin
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
        end
    end

    // MEM/WB register. Write-enable is held low for the whole access so a frozen
    // pipeline never retires a stale write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd_q    <= NOPRegAddr;
            wb_wreg_q  <= WriteDisable;
            wb_wdata_q <= ZeroWord;
        end else if (state_q == ST_IDLE) begin
            if (issue) begin
                wb_wreg_q  <= WriteDisable;
            end else begin
                wb_wd_q    <= mem_wd;
                wb_wreg_q  <= misalign ? WriteDisable : mem_wreg;
                wb_wdata_q <= misalign ? ZeroWord : mem_wdata;
            end
        end else if (done) begin
            wb_wd_q <= acc_wd_q;
            if (op_is_load(acc_op_q)) begin
                wb_wreg_q  <= acc_wreg_q;
                wb_wdata_q <= fmt_ldata;
            end else begin
                wb_wreg_q  <= WriteDisable;
                wb_wdata_q <= ZeroWord;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic excp_align_q;

    // One-cycle pulse: the trapping op is consumed at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excp_align_q <= 1'b0;
        end else begin
            excp_align_q <= (state_q == ST_IDLE) && misalign;
        end
    end

    assign excp_align = excp_align_q;
`else
    assign excp_align = 1'b0;
`endif

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_wd      = wb_wd_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_wdata   = wb_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected MEM/WB and bus transactions,
// a bus slave model checks requests and acks after programmed waits, a monitor pops
// and compares write-back results whenever an instruction is consumed (stallreq low).
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        bit          chk_data;
        logic        excp;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          waits;
        logic [31:0] rdata;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        excp_align;

    logic        instr_vld;

    wb_exp_t  sb_q[$];
    bus_exp_t bus_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_aluop  (mem_aluop),
        .mem_addr   (mem_addr),
        .mem_reg2   (mem_reg2),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack),
        .stallreq   (stallreq),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .excp_align (excp_align)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus slave: picks up a new request at the falling edge, counts down the programmed
    // wait states, then raises ack for exactly one cycle.
    bit       slv_busy = 1'b0;
    int       slv_cnt  = 0;
    bus_exp_t slv_cur;

    initial begin
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                slv_busy = 1'b0;
                dbus_ack = 1'b0;
            end else begin
                if (dbus_ack) begin
                    dbus_ack = 1'b0;
                    slv_busy = 1'b0;
                end
                if (dbus_req && !slv_busy) begin
                    slv_busy = 1'b1;
                    if (bus_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected_req: addr 0x%08h, no request expected", dbus_addr);
                        slv_cur = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0, 32'h0};
                        slv_cnt = 0;
                    end else begin
                        slv_cur = bus_q.pop_front();
                        slv_cnt = slv_cur.waits;
                        check32("bus_we", {31'b0, dbus_we}, {31'b0, slv_cur.we});
                        check32("bus_addr", dbus_addr, slv_cur.addr);
                        check32("bus_sel", {28'b0, dbus_sel}, {28'b0, slv_cur.sel});
                        if (slv_cur.chk_wdata) check32("bus_wdata", dbus_wdata, slv_cur.wdata);
                    end
                end
                if (slv_busy) begin
                    if (slv_cnt == 0) begin
                        dbus_ack   = 1'b1;
                        dbus_rdata = slv_cur.rdata;
                    end else begin
                        slv_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: an instruction is consumed at the rising edge following a settled
    // stallreq==0; its MEM/WB result is compared just after that edge.
    initial begin
        bit      fire;
        wb_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            fire = (rst === 1'b1) && instr_vld && (stallreq === 1'b0);
            if (fire) begin
                @(posedge clk);
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: wb_wd=%0d with no expected entry", wb_wd);
                end else begin
                    e = sb_q.pop_front();
                    check32("wb_wd", {27'b0, wb_wd}, {27'b0, e.wd});
                    check32("wb_wreg", {31'b0, wb_wreg}, {31'b0, e.wreg});
                    if (e.chk_data) check32("wb_wdata", wb_wdata, e.wdata);
                    check32("excp_align", {31'b0, excp_align}, {31'b0, e.excp});
                end
            end
        end
    end

    // Presents one instruction (called just after a rising edge) and holds it until
    // consumed, counting stalled cycles.
    task automatic send(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input wb_exp_t e, input bit has_bus,
                        input bus_exp_t b, input int exp_stall);
        int  stalls;
        bit  got;
        mem_aluop = op;
        mem_addr  = addr;
        mem_reg2  = reg2;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
        instr_vld = 1'b1;
        sb_q.push_back(e);
        if (has_bus) bus_q.push_back(b);
        stalls = 0;
        got    = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            #2;
            if (stallreq === 1'b0) got = 1'b1;
            else stalls++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: still stalled after 300 cycles", name);
        end else begin
            checks++;
            if (stalls != exp_stall) begin
                failures++;
                $display("FAIL %s_stall: got %0d stall cycles, expected %0d", name, stalls, exp_stall);
            end
        end
        @(posedge clk);
        #1;
    endtask

    bus_exp_t nob;

    initial begin
        nob       = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0, 32'h0};
        rst       = 1'b0;
        instr_vld = 1'b0;
        mem_aluop = OP_ADD;
        mem_addr  = 32'h0;
        mem_reg2  = 32'h0;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        mem_wdata = 32'h0;

        // Reset values
        #23;
        check32("rst_dbus_req", {31'b0, dbus_req}, 32'h0);
        check32("rst_dbus_we", {31'b0, dbus_we}, 32'h0);
        check32("rst_dbus_addr", dbus_addr, 32'h0);
        check32("rst_dbus_sel", {28'b0, dbus_sel}, 32'h0);
        check32("rst_dbus_wdata", dbus_wdata, 32'h0);
        check32("rst_wb_wd", {27'b0, wb_wd}, 32'h0);
        check32("rst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
        check32("rst_wb_wdata", wb_wdata, 32'h0);
        check32("rst_excp_align", {31'b0, excp_align}, 32'h0);
        check32("rst_stallreq", {31'b0, stallreq}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset while in ACCESS: slave never acks this one
        mem_aluop = EXE_LW_OP;
        mem_addr  = 32'h100;
        mem_wd    = 5'd1;
        mem_wreg  = 1'b1;
        bus_q.push_back('{1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 100, 32'h0});
        @(posedge clk);
        @(posedge clk);
        #3;
        check32("access_req_before_rst", {31'b0, dbus_req}, 32'h1);
        rst = 1'b0;
        #1;
        check32("midrst_dbus_req", {31'b0, dbus_req}, 32'h0);
        check32("midrst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
        mem_aluop = OP_ADD;
        #1;
        check32("midrst_stallreq", {31'b0, stallreq}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD passthrough (also shows the FSM came back in IDLE)
        send("add", OP_ADD, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678,
             '{5'd3, 1'b1, 32'h12345678, 1'b1, 1'b0}, 1'b0, nob, 0);

        // LB 0x1001, two wait states: lane 1 = 0xF2, sign-extended
        send("lb", EXE_LB_OP, 32'h1001, 32'h0, 5'd5, 1'b1, 32'h0,
             '{5'd5, 1'b1, 32'hFFFFFFF2, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h1000, 4'b0100, 32'h0, 1'b0, 2, 32'h11F23344}, 3);

        // SH 0x2002, immediate ack
        send("sh", EXE_SH_OP, 32'h2002, 32'hAAAABEEF, 5'd4, 1'b1, 32'h0,
             '{5'd4, 1'b0, 32'h0, 1'b0, 1'b0}, 1'b1,
             '{1'b1, 32'h2000, 4'b0011, 32'hBEEFBEEF, 1'b1, 0, 32'h0}, 1);

        // LHU 0x0 then LW 0x4 back-to-back
        send("lhu", EXE_LHU_OP, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0,
             '{5'd6, 1'b1, 32'h00008001, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h0, 4'b1100, 32'h0, 1'b0, 0, 32'h80017FFF}, 1);
        send("lw", EXE_LW_OP, 32'h4, 32'h0, 5'd7, 1'b1, 32'h0,
             '{5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h4, 4'b1111, 32'h0, 1'b0, 1, 32'hDEADBEEF}, 2);

        // LH upper-lane halfword, sign-extended
        send("lh", EXE_LH_OP, 32'h12, 32'h0, 5'd10, 1'b1, 32'h0,
             '{5'd10, 1'b1, 32'hFFFF8765, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h10, 4'b0011, 32'h0, 1'b0, 0, 32'h12348765}, 1);

        // LBU offset 3, zero-extended
        send("lbu", EXE_LBU_OP, 32'h23, 32'h0, 5'd11, 1'b1, 32'h0,
             '{5'd11, 1'b1, 32'h000000A5, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h20, 4'b0001, 32'h0, 1'b0, 0, 32'h000000A5}, 1);

        // SB offset 1 replicates the low byte
        send("sb", EXE_SB_OP, 32'h31, 32'h123456C3, 5'd12, 1'b1, 32'h0,
             '{5'd12, 1'b0, 32'h0, 1'b0, 1'b0}, 1'b1,
             '{1'b1, 32'h30, 4'b0100, 32'hC3C3C3C3, 1'b1, 1, 32'h0}, 2);

        // SW full word
        send("sw", EXE_SW_OP, 32'h40, 32'hCAFEF00D, 5'd13, 1'b0, 32'h0,
             '{5'd13, 1'b0, 32'h0, 1'b0, 1'b0}, 1'b1,
             '{1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, 1'b1, 0, 32'h0}, 1);

        // LW at 0x6: traps with the check enabled, otherwise accesses 0x4
`ifdef MEM_ALIGN_CHECK_EN
        send("lw_misalign", EXE_LW_OP, 32'h6, 32'h0, 5'd8, 1'b1, 32'h0,
             '{5'd8, 1'b0, 32'h0, 1'b0, 1'b1}, 1'b0, nob, 0);
`else
        send("lw_misalign", EXE_LW_OP, 32'h6, 32'h0, 5'd8, 1'b1, 32'h0,
             '{5'd8, 1'b1, 32'h0BADF00D, 1'b1, 1'b0}, 1'b1,
             '{1'b0, 32'h4, 4'b1111, 32'h0, 1'b0, 0, 32'h0BADF00D}, 1);
`endif

        // Trailing ADD: excp_align must be back to 0
        send("add2", OP_ADD, 32'h0, 32'h0, 5'd9, 1'b0, 32'h00000001,
             '{5'd9, 1'b0, 32'h00000001, 1'b1, 1'b0}, 1'b0, nob, 0);

        instr_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check32("sb_queue_drained", sb_q.size(), 32'd0);
        check32("bus_queue_drained", bus_q.size(), 32'd0);
        check32("idle_req_low", {31'b0, dbus_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage plus MEM/WB boundary register. Consumes the EX/MEM register outputs and runs loads and stores on a single-outstanding data-bus handshake, stalling the pipeline until the bus acknowledges. Its registered outputs feed write-back. Non-memory instructions pass through with one register of latency.

## Interface
- No parameters; widths come from shared defines (`RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8).
- clk  in  1  pipeline clock, all flops rising-edge
- rst  in  1  asynchronous, active-low reset
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  write-enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_aluop  in  8  operation code: LB/LBU/LH/LHU/LW/SB/SH/SW or other
- mem_addr  in  32  effective address
- mem_reg2  in  32  store source data
- dbus_req  out  1  bus request, held until ack
- dbus_we  out  1  1=store
- dbus_addr  out  32  word address, low 2 bits zero
- dbus_sel  out  4  byte lanes, big-endian (sel[3]=addr 0)
- dbus_wdata  out  32  store data, replicated into lanes
- dbus_rdata  in  32  load data, valid when ack
- dbus_ack  in  1  single-cycle completion strobe
- stallreq  out  1  to pipeline control; freezes PC..EX/MEM
- wb_wd  out  5  registered destination
- wb_wreg  out  1  registered write-enable
- wb_wdata  out  32  registered write data
- excp_align  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, non-memory op: at the clock edge, wb_* <= mem_wd/mem_wreg/mem_wdata; stallreq=0.
- IDLE, memory op: stallreq=1 combinationally; at the edge, go to ACCESS and register dbus_req=1, we, addr, sel, wdata; wb_wreg <= 0.
- ACCESS: outputs held stable; stallreq=1 until dbus_ack. In the ack cycle, stallreq=0. At that edge: return to IDLE, drop req, and load wb_*.
- Load result: select the lane by addr[1:0] (big-endian). LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. wb_wreg <= mem_wreg.
- Store: wb_wreg <= 0. sel is 1000/0100/0010/0001 for bytes at offsets 0..3, 1100/0011 for halfwords, 1111 for words. SB replicates reg2[7:0] into 4 lanes; SH replicates reg2[15:0] into 2.
- dbus_ack outside ACCESS is ignored.
- Reset (async, mid-transaction included): state=IDLE, dbus_req=0, dbus_we=0, dbus_addr/sel/wdata=0, wb_wd=0, wb_wreg=0, wb_wdata=0, excp_align=0. stallreq derives from state/inputs and is therefore 0 for a non-memory op. An in-flight transaction is abandoned; the slave must tolerate req dropping.

## Timing
- Non-memory: 1 cycle to wb_*.
- Memory, ack in first ACCESS cycle: 2 cycles (issue cycle + ack cycle), stallreq high for 1 cycle.
- Each wait state adds 1 cycle to the latency and 1 cycle to the stall.
- Upstream advances at the edge ending the ack cycle, so IDLE always sees a new instruction. Back-to-back memory ops re-enter ACCESS the following cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a halfword op with addr[0]=1 or a word op with addr[1:0]≠0 issues no bus access and raises no stall. At the edge, wb_wreg <= 0 and excp_align <= 1 for one cycle.
- Undefined: low address bits are ignored for halfword/word ops (lane chosen by the forced-aligned address), and excp_align is tied 0.

## Structure
- Shared defines file holds op codes (EXE_LB_OP...EXE_SW_OP), bus widths, ZeroWord, NOPRegAddr, WriteDisable and FSM state encodings.
- One combinational sub-module, mem_lane_fmt, builds sel/wdata from op/addr/reg2 and extracts/extends load data.

## Test plan
- Reset asserted while in ACCESS -> dbus_req falls immediately without clk, wb_wreg=0, and after release the FSM is in IDLE.
- ADD passthrough wd=3, wdata=0x12345678, wreg=1 -> next cycle wb_*=3/1/0x12345678, and stallreq is never high.
- LB addr=0x1001, rdata=0x11F23344, ack after 2 wait cycles -> sel=0100, stallreq high for 3 cycles, wb_wdata=0xFFFFFFF2.
- SH addr=0x2002, reg2=0xAAAABEEF, immediate ack -> we=1, sel=0011, wdata=0xBEEFBEEF, wb_wreg=0.
- LHU addr=0x0 then LW addr=0x4 back-to-back -> two distinct req phases, correct wb_wdata each time, no lost ack.
- With MEM_ALIGN_CHECK_EN, LW addr=0x6 -> no req, excp_align pulses once, wb_wreg=0. Without it -> access at 0x4, sel=1111.
